// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared opcode, ALU-operation and controller-state encodings
package mc_pkg;

    // Instruction opcodes, carried in IR[15:13]
    typedef enum logic [2:0] {
        OP_LDA = 3'b000,
        OP_STA = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_JMP = 3'b100,
        OP_JZ  = 3'b101,
        OP_AND = 3'b110,
        OP_HLT = 3'b111
    } opcode_t;

    // ALU operation select, shared with the ALU
    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_AND    = 2'b10,
        ALU_PASS_B = 2'b11
    } alu_op_t;

    // Controller states
    typedef enum logic [2:0] {
        S_FETCH_HI  = 3'd0,
        S_FETCH_LO  = 3'd1,
        S_DECODE    = 3'd2,
        S_MEM_RD    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_MEM_WR    = 3'd5,
        S_JUMP      = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    // Datapath mux selects
    localparam logic ADR_PC  = 1'b0;
    localparam logic ADR_IR  = 1'b1;
    localparam logic PC_INC  = 1'b0;
    localparam logic PC_IR   = 1'b1;
    localparam logic ACC_MEM = 1'b0;
    localparam logic ACC_ALU = 1'b1;

    // ALU operation used when writing back the result of a memory-operand instruction;
    // LDA passes the memory operand straight through.
    function automatic alu_op_t alu_op_for(input opcode_t op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_PASS_B;
        endcase
    endfunction

endpackage

// File: rtl/mc_instr_counter.sv
// rtl/mc_instr_counter.sv - retired-instruction counter, wraps at 2^CNT_W
module mc_instr_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count one retired instruction per enabled cycle; natural overflow gives the wrap to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle accumulator-machine control FSM
module mc_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_hi_write,
    output logic             ir_lo_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             acc_write,
    output logic             acc_src,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    state_t  state;
    state_t  state_next;
    opcode_t op_q;
    opcode_t op_in;
    logic    retire;

    assign op_in = opcode_t'(opcode);

    // State register; reset lands in FETCH_HI so the first fetch starts on release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH_HI;
        end else begin
            state <= state_next;
        end
    end

    // Opcode is captured in DECODE and steers the later execute states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= OP_LDA;
        end else if (state == S_DECODE) begin
            op_q <= op_in;
        end
    end

    // Next-state selection and retire pulse for the instruction counter
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            S_FETCH_HI: begin
                if (mem_ready) begin
                    state_next = S_FETCH_LO;
                end
            end
            S_FETCH_LO: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op_in)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND: state_next = S_MEM_RD;
                    OP_STA:                         state_next = S_MEM_WR;
                    OP_JMP:                         state_next = S_JUMP;
                    OP_JZ: begin
                        if (zero) begin
                            state_next = S_JUMP;
                        end else begin
                            state_next = S_FETCH_HI;
                            retire     = 1'b1;
                        end
                    end
                    default:                        state_next = S_HALT;
                endcase
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_next = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                state_next = S_FETCH_HI;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_next = S_FETCH_HI;
                    retire     = 1'b1;
                end
            end
            S_JUMP: begin
                state_next = S_FETCH_HI;
                retire     = 1'b1;
            end
            default: begin
                state_next = S_HALT;
            end
        endcase
    end

    // Strobe decode; fetch load strobes fire only on the completing cycle and never while in reset
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        adr_src     = ADR_PC;
        ir_hi_write = 1'b0;
        ir_lo_write = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_INC;
        acc_write   = 1'b0;
        acc_src     = ACC_MEM;
        alu_op      = ALU_ADD;
        halted      = 1'b0;
        case (state)
            S_FETCH_HI: begin
                mem_read = 1'b1;
                adr_src  = ADR_PC;
                if (mem_ready && !rst) begin
                    ir_hi_write = 1'b1;
                    pc_write    = 1'b1;
                end
            end
            S_FETCH_LO: begin
                mem_read = 1'b1;
                adr_src  = ADR_PC;
                if (mem_ready && !rst) begin
                    ir_lo_write = 1'b1;
                    pc_write    = 1'b1;
                end
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                adr_src  = ADR_IR;
            end
            S_WRITEBACK: begin
                acc_write = 1'b1;
                acc_src   = (op_q == OP_LDA) ? ACC_MEM : ACC_ALU;
                alu_op    = alu_op_for(op_q);
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                adr_src   = ADR_IR;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_IR;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    mc_instr_counter #(
        .CNT_W (CNT_W)
    ) u_instr_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (retire),
        .count (instr_count)
    );

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;

    // Strobe vector order: mem_read mem_write adr_src ir_hi ir_lo pc_write pc_src acc_write acc_src alu_op[1:0] halted
    localparam logic [11:0] E_FH_RDY  = 12'h940;
    localparam logic [11:0] E_FH_WAIT = 12'h800;
    localparam logic [11:0] E_FL_RDY  = 12'h8C0;
    localparam logic [11:0] E_DEC     = 12'h000;
    localparam logic [11:0] E_MR      = 12'hA00;
    localparam logic [11:0] E_WB_LDA  = 12'h016;
    localparam logic [11:0] E_WB_ADD  = 12'h018;
    localparam logic [11:0] E_WB_SUB  = 12'h01A;
    localparam logic [11:0] E_WB_AND  = 12'h01C;
    localparam logic [11:0] E_MW      = 12'h600;
    localparam logic [11:0] E_JUMP    = 12'h060;
    localparam logic [11:0] E_HALT    = 12'h001;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  opcode;
    logic        zero;
    logic        mem_ready;

    logic        mem_read, mem_write, adr_src, ir_hi_write, ir_lo_write;
    logic        pc_write, pc_src, acc_write, acc_src, halted;
    logic [1:0]  alu_op;
    logic [15:0] cnt16;

    logic        mem_read4, mem_write4, adr_src4, ir_hi_write4, ir_lo_write4;
    logic        pc_write4, pc_src4, acc_write4, acc_src4, halted4;
    logic [1:0]  alu_op4;
    logic [3:0]  cnt4;

    logic [11:0] strobes;
    assign strobes = {mem_read, mem_write, adr_src, ir_hi_write, ir_lo_write,
                      pc_write, pc_src, acc_write, acc_src, alu_op, halted};

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk (clk), .rst (rst), .opcode (opcode), .zero (zero), .mem_ready (mem_ready),
        .mem_read (mem_read), .mem_write (mem_write), .adr_src (adr_src),
        .ir_hi_write (ir_hi_write), .ir_lo_write (ir_lo_write), .pc_write (pc_write),
        .pc_src (pc_src), .acc_write (acc_write), .acc_src (acc_src), .alu_op (alu_op),
        .halted (halted), .instr_count (cnt16)
    );

    mc_controller #(.CNT_W (4)) dut4 (
        .clk (clk), .rst (rst), .opcode (opcode), .zero (zero), .mem_ready (mem_ready),
        .mem_read (mem_read4), .mem_write (mem_write4), .adr_src (adr_src4),
        .ir_hi_write (ir_hi_write4), .ir_lo_write (ir_lo_write4), .pc_write (pc_write4),
        .pc_src (pc_src4), .acc_write (acc_write4), .acc_src (acc_src4), .alu_op (alu_op4),
        .halted (halted4), .instr_count (cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Check the strobes of the current cycle, then move to just after the next rising edge
    task automatic at(input string tag, input logic [11:0] exp);
        #1;
        check(tag, {20'b0, strobes}, {20'b0, exp});
        @(posedge clk);
        #2;
    endtask

    task automatic chk_cnt(input string tag);
        #1;
        check({tag, "_cnt16"}, {16'b0, cnt16}, 32'(exp_cnt) & 32'hFFFF);
        check({tag, "_cnt4"},  {28'b0, cnt4},  32'(exp_cnt) & 32'hF);
    endtask

    task automatic run_mem(input logic [2:0] op, input logic [11:0] wb, input string tag);
        opcode = op;
        at({tag, "_fh"}, E_FH_RDY);
        at({tag, "_fl"}, E_FL_RDY);
        at({tag, "_dec"}, E_DEC);
        at({tag, "_mr"}, E_MR);
        at({tag, "_wb"}, wb);
        exp_cnt++;
        chk_cnt(tag);
    endtask

    task automatic run_branch(input logic [2:0] op, input logic z, input logic taken, input string tag);
        opcode = op;
        zero   = z;
        at({tag, "_fh"}, E_FH_RDY);
        at({tag, "_fl"}, E_FL_RDY);
        at({tag, "_dec"}, E_DEC);
        if (taken) at({tag, "_jump"}, E_JUMP);
        exp_cnt++;
        chk_cnt(tag);
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 3'b000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("reset_strobes", {20'b0, strobes}, {20'b0, E_FH_WAIT});
        check("reset_cnt", {16'b0, cnt16}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        run_mem(3'b000, E_WB_LDA, "lda");

        opcode = 3'b001;
        at("sta_fh", E_FH_RDY);
        at("sta_fl", E_FL_RDY);
        at("sta_dec", E_DEC);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) at("sta_mw_wait", E_MW);
        check("sta_cnt_hold", {16'b0, cnt16}, 32'(exp_cnt));
        mem_ready = 1'b1;
        at("sta_mw_done", E_MW);
        exp_cnt++;
        chk_cnt("sta");
        check("sta_next_fh", {20'b0, strobes}, {20'b0, E_FH_RDY});

        run_branch(3'b101, 1'b1, 1'b1, "jz_taken");
        run_branch(3'b101, 1'b0, 1'b0, "jz_untaken");
        run_mem(3'b010, E_WB_ADD, "add");
        run_mem(3'b011, E_WB_SUB, "sub");
        run_mem(3'b110, E_WB_AND, "and");

        mem_ready = 1'b0;
        at("fh_wait0", E_FH_WAIT);
        at("fh_wait1", E_FH_WAIT);
        mem_ready = 1'b1;
        run_branch(3'b100, 1'b0, 1'b1, "jmp");

        opcode = 3'b000;
        at("rmr_fh", E_FH_RDY);
        at("rmr_fl", E_FL_RDY);
        at("rmr_dec", E_DEC);
        mem_ready = 1'b0;
        at("rmr_mr_wait0", E_MR);
        at("rmr_mr_wait1", E_MR);
        rst       = 1'b1;
        mem_ready = 1'b1;
        exp_cnt   = 0;
        #1;
        check("rmr_in_reset", {20'b0, strobes}, {20'b0, E_FH_WAIT});
        chk_cnt("rmr_reset");
        @(posedge clk);
        #2;
        rst       = 1'b0;
        mem_ready = 1'b0;
        at("rmr_post_wait", E_FH_WAIT);
        mem_ready = 1'b1;
        at("rmr_post_fh", E_FH_RDY);
        at("rmr_post_fl", E_FL_RDY);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) run_mem(3'b010, E_WB_ADD, "wrap_add");
        check("wrap_cnt4_final", {28'b0, cnt4}, 32'd1);

        opcode = 3'b111;
        at("hlt_fh", E_FH_RDY);
        at("hlt_fl", E_FL_RDY);
        at("hlt_dec", E_DEC);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            at("halt", E_HALT);
        end
        chk_cnt("halt");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
